// File: rtl/store_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue_pkg
//  Description : Shared types and helpers for the buffered store unit.
//                Provides the store opcodes, the back-end state encoding,
//                the queued entry layout and the big-endian lane formatter.
//                The optional STORE_BYTEEN_EN build does not change anything
//                in this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_queue_pkg;

  // Queue entries always carry a full 32-bit address. Narrower bus addresses
  // are zero-extended on entry and truncated on exit.
  localparam int SQ_ADDR_W = 32;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;  // word address, bits [1:0] are zero
    logic [31:0]          data;  // lane-formatted store data
    logic [3:0]           be;    // lane enables
  } store_entry_t;

  typedef struct packed {
    logic        legal;  // opcode known and address aligned for its size
    logic [31:0] data;
    logic [3:0]  be;
  } lane_fmt_t;

  // Place the register bytes onto big-endian lanes: lane k holds the byte at
  // word offset k, so the most significant register byte lands on the lowest
  // address. Unused lanes are left at zero.
  function automatic lane_fmt_t format_store(input logic [5:0]  op,
                                             input logic [1:0]  offset,
                                             input logic [31:0] src);
    lane_fmt_t f;
    f.legal = 1'b0;
    f.data  = '0;
    f.be    = '0;
    case (op)
      OP_SW: begin
        if (offset == 2'b00) begin
          f.legal = 1'b1;
          f.data  = {src[7:0], src[15:8], src[23:16], src[31:24]};
          f.be    = 4'b1111;
        end
      end
      OP_SH: begin
        if (!offset[0]) begin
          f.legal = 1'b1;
          if (offset[1]) begin
            f.data[23:16] = src[15:8];
            f.data[31:24] = src[7:0];
            f.be          = 4'b1100;
          end else begin
            f.data[7:0]   = src[15:8];
            f.data[15:8]  = src[7:0];
            f.be          = 4'b0011;
          end
        end
      end
      OP_SB: begin
        f.legal = 1'b1;
        f.data  = {24'b0, src[7:0]} << {offset, 3'b000};
        f.be    = 4'b0001 << offset;
      end
      default: begin
        f.legal = 1'b0;
      end
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_queue_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : store_fifo
//  Description : Synchronous FIFO of store entries. The head entry is read
//                combinationally; push when full and pop when empty are
//                ignored. Not affected by STORE_BYTEEN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_fifo
  import store_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  store_entry_t                 wr_entry,
  input  logic                         pop,
  output store_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  store_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[rd_ptr];

  // Entry storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; a simultaneous
  // push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue_unit
//  Description : Buffered MIPS store unit. Formats sb/sh/sw into big-endian
//                byte lanes, queues them and drains the queue to an
//                Avalon-style bus. Default build performs a read-modify-write
//                per store; defining STORE_BYTEEN_EN replaces that with a
//                single byte-enabled write and adds the mem_byteenable port.
//                ADDR_W must not exceed 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_queue_unit
  import store_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       mem_writedata
`ifdef STORE_BYTEEN_EN
  ,
  output logic [3:0]        mem_byteenable
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

`ifdef STORE_BYTEEN_EN
  localparam state_t FIRST_STATE = S_WRITE;
`else
  localparam state_t FIRST_STATE = S_READ;
`endif

  state_t           state;
  state_t           state_next;
  lane_fmt_t        fmt;
  store_entry_t     new_entry;
  store_entry_t     head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             accept;
  logic             push;
  logic             reject;
  logic             pop;
  logic             more;
  logic [31:0]      write_word;

  // Front end: format the incoming request and split accepted requests into
  // enqueue or reject. Rejections consume the handshake but not a slot.
  always_comb begin
    fmt = format_store(req_op, req_addr[1:0], req_data);
  end

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && fmt.legal;
  assign reject    = accept && !fmt.legal;

  // Build the queue entry with a word-aligned, zero-extended address.
  always_comb begin
    new_entry                    = '0;
    new_entry.addr[ADDR_W-1:2]   = req_addr[ADDR_W-1:2];
    new_entry.data               = fmt.data;
    new_entry.be                 = fmt.be;
  end

  // Registered error report, visible the cycle after the rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= reject;
      if (reject) begin
        err_addr <= req_addr;
      end
    end
  end

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wr_entry (new_entry),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The head retires when its write is accepted by the bus. A push in the
  // same cycle counts as a remaining entry so the drain has no bubble.
  assign pop  = (state == S_WRITE) && !mem_waitrequest;
  assign more = (fifo_count > CNT_W'(1)) || push;

  assign empty = fifo_empty && (state == S_IDLE);

  // Back-end state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Back-end next-state: every bus phase waits out mem_waitrequest.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_next = FIRST_STATE;
        end
      end
      S_READ: begin
        if (!mem_waitrequest) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!mem_waitrequest) begin
          state_next = more ? FIRST_STATE : S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef STORE_BYTEEN_EN
  // Byte-enabled writes carry only the formatted lanes; read data is unused.
  logic unused_readdata;
  assign unused_readdata = ^mem_readdata;
  assign write_word      = head.data;
`else
  logic [31:0] rd_word;

  // Capture the old memory word when the read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_word <= '0;
    end else if ((state == S_READ) && !mem_waitrequest) begin
      rd_word <= mem_readdata;
    end
  end

  // Merge: enabled lanes come from the store, the rest from the old word.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign write_word[8*k +: 8] = head.be[k] ? head.data[8*k +: 8]
                                             : rd_word[8*k +: 8];
  end
`endif

  // Back-end outputs depend only on state and the head entry, so they stay
  // stable for as long as the bus stalls.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
`ifdef STORE_BYTEEN_EN
    mem_byteenable = '0;
`endif
    case (state)
      S_READ: begin
        mem_read    = 1'b1;
        mem_address = head.addr[ADDR_W-1:0];
      end
      S_WRITE: begin
        mem_write     = 1'b1;
        mem_address   = head.addr[ADDR_W-1:0];
        mem_writedata = write_word;
`ifdef STORE_BYTEEN_EN
        mem_byteenable = head.be;
`endif
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_store_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_queue_unit
//  Description : Scoreboard bench for store_queue_unit. A byte-level model of
//                big-endian memory predicts every bus write and every error
//                report; a negedge monitor plays the bus slave and compares.
//                Works with and without STORE_BYTEEN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_queue_unit;

  localparam int DEPTH = 4;
  localparam logic [5:0] T_SB = 6'b101000;
  localparam logic [5:0] T_SH = 6'b101001;
  localparam logic [5:0] T_SW = 6'b101011;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        empty;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic [31:0] mem_writedata;
`ifdef STORE_BYTEEN_EN
  logic [3:0]  mem_byteenable;
`endif

  int total = 0;
  int bad = 0;
  int wait_mode = 0;   // 0: never stall, 1: random stalls, 2: stall always
  int n_bus = 0;

  exp_t        exp_q[$];
  logic [31:0] err_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  store_queue_unit #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .empty           (empty),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .mem_writedata   (mem_writedata)
`ifdef STORE_BYTEEN_EN
    ,
    .mem_byteenable  (mem_byteenable)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (be[k]) m = m | (32'hFF << (8 * k));
    return m;
  endfunction

  // Model a store as bytes written to consecutive addresses, MSB first.
  function automatic void model_issue(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] d);
    int n;
    int off;
    logic [31:0] wa;
    logic [31:0] w;
    logic [3:0]  be;
    exp_t e;
    n = (op == T_SW) ? 4 : (op == T_SH) ? 2 : (op == T_SB) ? 1 : 0;
    if (n == 0 || (a % n) != 0) begin
      err_q.push_back(a);
      return;
    end
    wa = a & ~32'h3;
    w  = model_rd(wa);
    be = '0;
    for (int i = 0; i < n; i++) begin
      off = (int'(a[1:0]) + i) % 4;
      w[8*off +: 8] = 8'(d >> (8 * (n - 1 - i)));
      be[off] = 1'b1;
    end
    model_mem[wa] = w;
    e.addr = wa;
    e.word = w;
    e.be   = be;
    exp_q.push_back(e);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int guard;
    guard = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    model_issue(op, a, d);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (!empty && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_done", empty, 1'b1);
    check("drain_exp_left", exp_q.size(), 0);
  endtask

  // Bus slave and scoreboard monitor: decides the stall for the current
  // cycle, serves read data and retires completed transfers.
  logic        prev_wait = 1'b0;
  logic [65:0] prev_bus = '0;
  logic        rd_seen = 1'b0;
  logic [31:0] last_rd = '0;
  always @(negedge clk) begin
    logic w;
    exp_t e;
    if (!rst_n) begin
      prev_wait = 1'b0;
      rd_seen   = 1'b0;
      mem_waitrequest = (wait_mode == 2);
    end else begin
      if (prev_wait && (prev_bus[65] || prev_bus[64]))
        check("bus_stable", {31'b0, prev_bus == {mem_read, mem_write, mem_address, mem_writedata}}, 1);
      case (wait_mode)
        0:       w = 1'b0;
        1:       w = ($urandom_range(0, 99) < 30);
        default: w = 1'b1;
      endcase
      mem_waitrequest = w;
      mem_readdata = bus_rd(mem_address);
`ifdef STORE_BYTEEN_EN
      if (mem_read) check("no_read_in_be_mode", mem_read, 1'b0);
`endif
      if (mem_read && !w) begin
        last_rd = mem_address;
        rd_seen = 1'b1;
        n_bus++;
      end
      if (mem_write && !w) begin
        n_bus++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_address, mem_writedata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_address, e.addr);
`ifdef STORE_BYTEEN_EN
          check("wr_be", {28'b0, mem_byteenable}, {28'b0, e.be});
          check("wr_data", mem_writedata, e.word & be_mask(e.be));
          bus_mem[mem_address] = (bus_rd(mem_address) & ~be_mask(mem_byteenable)) |
                                 (mem_writedata & be_mask(mem_byteenable));
`else
          check("rmw_read_first", {31'b0, rd_seen && (last_rd == mem_address)}, 1);
          rd_seen = 1'b0;
          check("wr_data", mem_writedata, e.word);
          bus_mem[mem_address] = mem_writedata;
`endif
        end
      end
      if (err_valid) begin
        if (err_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_err: got err_addr %h expected no error", err_addr);
        end else begin
          check("err_addr", err_addr, err_q.pop_front());
        end
      end
      prev_wait = w;
      prev_bus  = {mem_read, mem_write, mem_address, mem_writedata};
    end
  end

  initial begin
    int k;
    int snap;
    logic [5:0]  op;
    logic [31:0] a;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_err_valid", err_valid, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sw 0x11223344 @0x100, zero wait states, with drain latency
    issue(T_SW, 32'h100, 32'h11223344);
    check("empty_falls", empty, 1'b0);
    k = 0;
    while (!empty && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
`ifdef STORE_BYTEEN_EN
    check("sw_cycles", k, 2);
`else
    check("sw_cycles", k, 3);
`endif
    check("sw_word", bus_rd(32'h100), 32'h44332211);

    // sb 0xAB @0x202 over 0xDDCCBBAA
    bus_mem[32'h200]   = 32'hDDCCBBAA;
    model_mem[32'h200] = 32'hDDCCBBAA;
    issue(T_SB, 32'h202, 32'h000000AB);
    wait_drain();
    check("sb_word", bus_rd(32'h200), 32'hDDABBBAA);

    // Misaligned requests are rejected without bus traffic
    snap = n_bus;
    issue(T_SH, 32'h101, 32'h1234);
    issue(T_SW, 32'h102, 32'h5678);
    repeat (3) begin @(posedge clk); #1; end
    check("err_all_seen", err_q.size(), 0);
    check("err_no_bus", n_bus, snap);
    check("err_empty", empty, 1'b1);

    // Fill with the bus stalled, then release
    wait_mode = 2;
    for (int i = 0; i < DEPTH; i++) issue(T_SW, 32'h300 + 32'(4 * i), $urandom);
    check("full_not_ready", req_ready, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    check("full_still_not_ready", req_ready, 1'b0);
    wait_mode = 0;
    issue(T_SB, 32'h301, 32'h000000C3);
    wait_drain();

    // Randomized traffic with random stalls and gaps
    wait_mode = 1;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = T_SB;
        3, 4, 5: op = T_SH;
        6, 7, 8: op = T_SW;
        default: op = 6'($urandom);
      endcase
      a = ($urandom_range(0, 1) != 0 ? 32'h400 : 32'h0) + 32'($urandom_range(0, 31));
      issue(op, a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();
    repeat (3) begin @(posedge clk); #1; end
    check("rand_err_left", err_q.size(), 0);

    // Reset mid-READ with two entries queued
    wait_mode = 2;
    issue(T_SW, 32'h800, 32'hCAFEF00D);
    issue(T_SW, 32'h804, 32'h0BADBEEF);
    k = 0;
    while (!mem_read && !mem_write && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("busy_before_reset", {31'b0, mem_read || mem_write}, 1);
    rst_n = 1'b0;
    #1;
    check("arst_mem_read", mem_read, 1'b0);
    check("arst_mem_write", mem_write, 1'b0);
    check("arst_mem_address", mem_address, 32'h0);
    check("arst_mem_writedata", mem_writedata, 32'h0);
    check("arst_err_addr", err_addr, 32'h0);
    check("arst_empty", empty, 1'b1);
    check("arst_req_ready", req_ready, 1'b1);
`ifdef STORE_BYTEEN_EN
    check("arst_byteenable", {28'b0, mem_byteenable}, 32'h0);
`endif
    exp_q.delete();
    wait_mode = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    snap = n_bus;
    repeat (20) begin @(posedge clk); #1; end
    check("post_reset_no_bus", n_bus, snap);
    check("post_reset_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_queue_unit.md
# store_queue_unit

Buffered store unit for the MIPS CPU data-memory port. Accepts `sb`/`sh`/`sw` requests from the execute stage, formats them into big-endian byte lanes with byte enables, and queues them in a `DEPTH`-entry FIFO. A back-end FSM drains the queue to the Avalon-style data bus. By default each store is a read-modify-write; with `STORE_BYTEEN_EN` it is a single byte-enabled write.

## Interface
Parameters:
- `DEPTH`, 4: store-queue entries; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: store request present.
- `req_ready` out 1: queue can accept this cycle.
- `req_op` in 6: `101000` sb, `101001` sh, `101011` sw.
- `req_addr` in ADDR_W: effective byte address.
- `req_data` in 32: source register value.
- `err_valid` out 1: one-cycle pulse; request rejected (misaligned or bad opcode).
- `err_addr` out ADDR_W: `req_addr` of the rejected request.
- `empty` out 1: queue empty and FSM in IDLE. The CPU stalls loads while this is 0.
- `mem_address` out ADDR_W: word address; bits [1:0] are always 0.
- `mem_read` out 1: bus read strobe.
- `mem_write` out 1: bus write strobe.
- `mem_waitrequest` in 1: bus stall.
- `mem_readdata` in 32: read data, valid when `mem_read && !mem_waitrequest`.
- `mem_writedata` out 32: write data.
- `mem_byteenable` out 4: lane enables. Present only with `STORE_BYTEEN_EN`.

## Operation
- Lane convention: lane k is bits [8k+7:8k] and holds the byte at word offset k. Big-endian, so the register MSB goes to the lowest address.
- sw: lane0 = data[31:24], lane1 = [23:16], lane2 = [15:8], lane3 = [7:0]; be = 1111.
- sh at offset 0: lane0 = data[15:8], lane1 = data[7:0]; be = 0011.
- sh at offset 2: lane2 = data[15:8], lane3 = data[7:0]; be = 1100.
- sb at offset k: lane k = data[7:0]; be has only bit k set.
- Unused lanes in an entry are 0.
- Rejection: sh with addr[0] = 1, sw with addr[1:0] ≠ 0, or any other opcode. The request is not enqueued. `err_valid` = 1 and `err_addr` are registered and appear the next cycle.
- A request is accepted when `req_valid && req_ready`. `req_ready = (count != DEPTH)`, computed from the registered count. A pop in the same cycle does not free a slot for that cycle.
- Each FIFO entry holds {word address, lane data, be}.
- FSM, RMW mode (default): IDLE → READ → WRITE.
  - IDLE: go to READ when the queue is non-empty.
  - READ: drive `mem_read` = 1 with the head address. On `!mem_waitrequest`, capture `mem_readdata` and go to WRITE.
  - WRITE: `mem_writedata` = per lane, be ? entry lane : captured lane. On `!mem_waitrequest`, pop the head, then go to READ if another entry remains, else IDLE.
- FSM with `STORE_BYTEEN_EN`: IDLE → WRITE → (WRITE | IDLE). READ is never entered and `mem_read` stays 0.
- Bus outputs are held stable while `mem_waitrequest` = 1.
- Simultaneous push and pop: count is unchanged, FIFO order is preserved, no entry is lost.
- Reset (async, any time):
  - State → IDLE; count → 0; in-flight bus transaction abandoned.
  - `mem_read`, `mem_write`, `mem_writedata`, `mem_address`, `mem_byteenable`, `err_valid`, `err_addr` → 0.
  - `req_ready` = 1, `empty` = 1.

## Timing
- Accept at edge N. The entry is visible to the FSM at N+1, which enters READ (or WRITE) at N+1.
- Zero wait states:
  - RMW: 2 cycles per store; first `mem_write` at N+2.
  - Byte-enable mode: 1 cycle per store; first `mem_write` at N+1.
- Back-to-back drain has no idle bubble between entries.
- `empty` falls the cycle after the first accept. It rises the cycle after the last pop.

## Configuration
- `STORE_BYTEEN_EN` defined:
  - `mem_byteenable` port exists and carries the entry's be during WRITE (0 otherwise).
  - No bus reads are issued.
  - Unused lanes of `mem_writedata` are 0.
- `STORE_BYTEEN_EN` undefined:
  - No `mem_byteenable` port.
  - Every store is a read-modify-write; sw also reads, for uniform timing.

## Structure
- Package `store_queue_pkg` holds:
  - opcode constants `OP_SB`, `OP_SH`, `OP_SW`;
  - state enum `{S_IDLE, S_READ, S_WRITE}`;
  - packed struct `store_entry_t` {addr, data[31:0], be[3:0]};
  - lane-format function.
- Sub-module `store_fifo`: a parametrised synchronous FIFO of `store_entry_t`, with push, pop, full, empty and count.

## Test plan
- sw 0x11223344 @0x100, no wait states → READ @0x100, then WRITE data 0x44332211 (lane0 = 0x11), 2 cycles; `empty` returns to 1.
- sb 0x000000AB @0x202 with memory word 0xDDCCBBAA → written word 0xDDABBBAA. With `STORE_BYTEEN_EN`: single write, be = 0100, lane2 = 0xAB.
- sh @0x101 and sw @0x102 → `err_valid` pulses with `err_addr` 0x101, then 0x102; no bus activity.
- Issue DEPTH+1 stores with `mem_waitrequest` held 1 → `req_ready` = 0 after DEPTH accepts. Release the stall → stores drain in order, then the last one is accepted.
- Assert `rst_n` = 0 mid-READ with 2 entries queued → all outputs 0 and `empty` = 1 immediately. After release, no bus traffic occurs.
